execute_muldiv: RTL and testbench

- Iterative multiply/divide unit in the execute stage, alongside the ALU. It consumes the execute-stage operands (e_rd0, e_rd1) and owns the architectural HI/LO registers.
- While an operation runs, it asserts stall to hold the fetch, decode and execute pipeline registers.
- It serves MULT, MULTU, DIV, DIVU, MTHI and MTLO. MFHI/MFLO read the hi/lo outputs combinationally through the result mux.

---
 rtl/execute_muldiv.sv | 163 ++++++++++++++++
 tb/tb_execute_muldiv.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/execute_muldiv.sv
// Iterative radix-2 multiply/divide unit for the execute stage; owns the HI/LO
// registers and stalls the front of the pipeline while an operation is in flight.
module execute_muldiv #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             flush,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             we_hi,
  input  logic             we_lo,
  input  logic [WIDTH-1:0] wd,
  output logic             stall,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic logic [WIDTH-1:0] neg_if(input logic [WIDTH-1:0] v, input logic neg);
    return neg ? (~v + WIDTH'(1)) : v;
  endfunction

  state_t             state_r;
  logic [CW-1:0]      count_r;
  logic               is_div_r;
  logic               sign_a_r;
  logic               sign_b_r;
  logic               b_zero_r;
  logic [WIDTH-1:0]   opnd_r;   // multiplicand or divisor magnitude
  logic [2*WIDTH-1:0] work_r;   // product, or {remainder, dividend/quotient}
  logic [WIDTH-1:0]   hi_r;
  logic [WIDTH-1:0]   lo_r;
  logic               done_r;

  logic               signed_s;
  logic               sign_a_s;
  logic               sign_b_s;
  logic [WIDTH-1:0]   abs_a_s;
  logic [WIDTH-1:0]   abs_b_s;
  logic [WIDTH:0]     mul_sum_s;
  logic [WIDTH:0]     div_shift_s;
  logic [WIDTH+1:0]   div_trial_s;
  logic               div_qbit_s;
  logic [WIDTH-1:0]   div_rem_s;
  logic [2*WIDTH-1:0] work_next_s;
  logic [2*WIDTH-1:0] product_s;
  logic [WIDTH-1:0]   res_hi_s;
  logic [WIDTH-1:0]   res_lo_s;
  logic               unused_s;

  assign stall = (state_r == BUSY) | ((state_r == IDLE) & start & ~flush);
  assign done  = done_r;
  assign hi    = hi_r;
  assign lo    = lo_r;

  // Operand conditioning at issue: magnitudes and signs for signed ops only
  always_comb begin
    signed_s = ~op[0];
    sign_a_s = signed_s & a[WIDTH-1];
    sign_b_s = signed_s & b[WIDTH-1];
    abs_a_s  = neg_if(a, sign_a_s);
    abs_b_s  = neg_if(b, sign_b_s);
  end

  // One radix-2 step plus sign-corrected result for the final step
  always_comb begin
    mul_sum_s   = {1'b0, work_r[2*WIDTH-1:WIDTH]} +
                  (work_r[0] ? {1'b0, opnd_r} : {(WIDTH+1){1'b0}});
    div_shift_s = {work_r[2*WIDTH-1:WIDTH], work_r[WIDTH-1]};
    div_trial_s = {1'b0, div_shift_s} - {2'b00, opnd_r};
    div_qbit_s  = ~div_trial_s[WIDTH+1];
    unused_s    = div_trial_s[WIDTH];
    if (div_qbit_s) begin
      div_rem_s = div_trial_s[WIDTH-1:0];
    end else begin
      div_rem_s = div_shift_s[WIDTH-1:0];
    end
    if (is_div_r) begin
      work_next_s = {div_rem_s, work_r[WIDTH-2:0], div_qbit_s};
    end else begin
      work_next_s = {mul_sum_s, work_r[WIDTH-1:1]};
    end
    product_s = (sign_a_r ^ sign_b_r) ? (~work_next_s + (2*WIDTH)'(1)) : work_next_s;
    if (is_div_r) begin
      // Divide by zero leaves remainder == dividend; only the quotient is forced
      res_lo_s = b_zero_r ? {WIDTH{1'b1}}
                          : neg_if(work_next_s[WIDTH-1:0], sign_a_r ^ sign_b_r);
      res_hi_s = neg_if(work_next_s[2*WIDTH-1:WIDTH], sign_a_r);
    end else begin
      res_lo_s = product_s[WIDTH-1:0];
      res_hi_s = product_s[2*WIDTH-1:WIDTH];
    end
  end

  // Control FSM, iteration datapath and HI/LO registers
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_r  <= IDLE;
      count_r  <= {CW{1'b0}};
      is_div_r <= 1'b0;
      sign_a_r <= 1'b0;
      sign_b_r <= 1'b0;
      b_zero_r <= 1'b0;
      opnd_r   <= {WIDTH{1'b0}};
      work_r   <= {(2*WIDTH){1'b0}};
      hi_r     <= {WIDTH{1'b0}};
      lo_r     <= {WIDTH{1'b0}};
      done_r   <= 1'b0;
    end else begin
      done_r <= 1'b0;
      case (state_r)
        IDLE: begin
          if (we_hi) hi_r <= wd;
          if (we_lo) lo_r <= wd;
          if (start && !flush) begin
            is_div_r <= op[1];
            sign_a_r <= sign_a_s;
            sign_b_r <= sign_b_s;
            b_zero_r <= (b == {WIDTH{1'b0}});
            opnd_r   <= op[1] ? abs_b_s : abs_a_s;
            work_r   <= {{WIDTH{1'b0}}, (op[1] ? abs_a_s : abs_b_s)};
            count_r  <= {CW{1'b0}};
            state_r  <= BUSY;
          end
        end
        BUSY: begin
          if (flush) begin
            state_r <= IDLE;
          end else begin
            work_r  <= work_next_s;
            count_r <= count_r + CW'(1);
            if (count_r == CW'(WIDTH-1)) begin
              hi_r    <= res_hi_s;
              lo_r    <= res_lo_s;
              done_r  <= 1'b1;
              state_r <= DONE;
            end
          end
        end
        DONE: begin
          if (we_hi) hi_r <= wd;
          if (we_lo) lo_r <= wd;
          state_r <= IDLE;
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_execute_muldiv.sv
// Randomized and directed bench for execute_muldiv against an arithmetic
// reference of MULT/MULTU/DIV/DIVU results and the pipeline-visible timing.
module tb_execute_muldiv;

  logic        clock;
  logic        reset;
  logic        flush;
  logic        start;
  logic [1:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        we_hi;
  logic        we_lo;
  logic [31:0] wd;
  logic        stall;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_hi;
  logic [31:0] exp_lo;

  execute_muldiv #(.WIDTH(32)) dut (
    .clock(clock), .reset(reset), .flush(flush), .start(start), .op(op),
    .a(a), .b(b), .we_hi(we_hi), .we_lo(we_lo), .wd(wd),
    .stall(stall), .done(done), .hi(hi), .lo(lo)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] expv);
    checks++;
    if (got !== expv) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, got, expv);
    end
  endtask

  // {hi, lo} computed with plain wide integer arithmetic
  function automatic logic [63:0] ref_result(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    longint sx;
    longint sy;
    logic [63:0] q;
    logic [63:0] r;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    case (o)
      2'd0: return 64'(sx * sy);
      2'd1: return {32'd0, x} * {32'd0, y};
      default: begin
        if (y == 32'd0) return {x, 32'hFFFF_FFFF};
        if (o == 2'd2) begin
          q = 64'(sx / sy);
          r = 64'(sx % sy);
        end else begin
          q = {32'd0, x / y};
          r = {32'd0, x % y};
        end
        return {r[31:0], q[31:0]};
      end
    endcase
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0: return 32'h0000_0000;
      1: return 32'h0000_0001;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'h7FFF_FFFF;
      5: return 32'($urandom_range(0, 20));
      default: return 32'($urandom);
    endcase
  endfunction

  task automatic step();
    @(negedge clock);
    #1;
  endtask

  // Issue one op at the current cycle (cycle 0) and follow it to completion
  task automatic run_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y, input bit hold);
    logic [63:0] res;
    int done_cyc;
    int stall_bad;
    res = ref_result(o, x, y);
    done_cyc = 0;
    stall_bad = 0;
    op = o; a = x; b = y; start = 1'b1;
    #1;
    check("stall_cycle0", {63'd0, stall}, 64'd1);
    for (int cyc = 1; cyc <= 40; cyc++) begin
      step();
      if (done) begin
        done_cyc = cyc;
        break;
      end
      if (!stall) stall_bad++;
      if (!hold) start = 1'b0;
    end
    check("done_cycle", 64'(done_cyc), 64'd33);
    check("busy_stall", 64'(stall_bad), 64'd0);
    check("stall_in_done", {63'd0, stall}, 64'd0);
    check("hi", {32'd0, hi}, {32'd0, res[63:32]});
    check("lo", {32'd0, lo}, {32'd0, res[31:0]});
    exp_hi = res[63:32];
    exp_lo = res[31:0];
    step();
    start = 1'b0;
    #1;
    check("no_second_op", {62'd0, stall, done}, 64'd0);
  endtask

  initial begin
    reset = 1'b1; flush = 1'b0; start = 1'b0; op = 2'd0; a = 32'd0; b = 32'd0;
    we_hi = 1'b0; we_lo = 1'b0; wd = 32'd0;
    exp_hi = 32'd0; exp_lo = 32'd0;
    step();
    step();
    check("reset_hi", {32'd0, hi}, 64'd0);
    check("reset_lo", {32'd0, lo}, 64'd0);
    check("reset_outs", {62'd0, stall, done}, 64'd0);
    reset = 1'b0;
    step();

    run_op(2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    check("multu_max_hi", {32'd0, hi}, 64'hFFFF_FFFE);
    run_op(2'd0, 32'hFFFF_FFFD, 32'd7, 1'b0);
    run_op(2'd0, 32'h8000_0000, 32'h8000_0000, 1'b0);
    run_op(2'd2, 32'hFFFF_FFF9, 32'd2, 1'b0);
    run_op(2'd3, 32'd7, 32'd2, 1'b0);
    run_op(2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    run_op(2'd3, 32'h0000_1234, 32'd0, 1'b1);
    run_op(2'd2, 32'hFFFF_FF00, 32'd0, 1'b0);

    // MTLO / MTHI in IDLE, then flush of a running MULTU
    we_lo = 1'b1; wd = 32'h55;
    step();
    we_lo = 1'b0;
    check("mtlo", {32'd0, lo}, 64'h55);
    we_hi = 1'b1; wd = 32'hAA;
    step();
    we_lo = 1'b1; we_hi = 1'b0; wd = 32'hBB;
    step();
    we_lo = 1'b0;
    op = 2'd1; a = 32'($urandom); b = 32'($urandom); start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 1; i < 10; i++) step();
    flush = 1'b1;
    step();
    flush = 1'b0;
    #1;
    check("flush_outs", {62'd0, stall, done}, 64'd0);
    check("flush_hi", {32'd0, hi}, 64'hAA);
    check("flush_lo", {32'd0, lo}, 64'hBB);
    run_op(2'd1, 32'd12345, 32'd678, 1'b0);

    // MTHI while busy is dropped; reset mid-op clears immediately
    op = 2'd0; a = 32'd99; b = 32'd3; start = 1'b1;
    step();
    start = 1'b0;
    we_hi = 1'b1; wd = 32'hDEAD_BEEF;
    step();
    we_hi = 1'b0;
    step();
    check("mthi_busy", {32'd0, hi}, {32'd0, exp_hi});
    step();
    step();
    step();
    reset = 1'b1;
    #1;
    check("rst_mid_hilo", {hi, lo}, 64'd0);
    check("rst_mid_outs", {62'd0, stall, done}, 64'd0);
    step();
    reset = 1'b0;
    step();

    for (int i = 0; i < 40; i++) begin
      run_op(2'($urandom_range(0, 3)), pick(), pick(), (i % 5) == 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
